// File: rtl/raiz_requester.sv
// raiz_requester: issues one square-root request to an accelerator, waits for the answer, checks the root and reports it.
module raiz_requester #(
    parameter int n       = 8,
    parameter int TIMEOUT = 31
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [n-1:0]   operand,
    output logic [n-1:0]   data_in,
    output logic           data_ready,
    input  logic           done,
    input  logic [n/2-1:0] raiz,
    input  logic [3:0]     ciclos,
    output logic           busy,
    output logic [n/2-1:0] result,
    output logic [3:0]     cycles,
    output logic           valid,
    output logic           error,
    output logic           timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [n+1:0] ONE_X = (n+2)'(1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CLR, WAIT_DONE, CHECK, REPORT} state_t;
    state_t         state_q, state_d;
    logic [n-1:0]   data_in_q, data_in_d;
    logic [n/2-1:0] result_q, result_d;
    logic [3:0]     cycles_q, cycles_d;
    logic           error_q, error_d, timeout_q, timeout_d;
    logic           data_ready_q, busy_q, valid_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [n+1:0]   r_x, op_x, lo, hi;
    logic           expired;
    always_comb begin
        state_d   = state_q;
        data_in_d = data_in_q;
        result_d  = result_q;
        cycles_d  = cycles_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        // bounds are widened by two bits so (result+1)^2 cannot wrap
        r_x       = {{(n/2+2){1'b0}}, result_q};
        op_x      = {2'b00, data_in_q};
        lo        = r_x * r_x;
        hi        = (r_x + ONE_X) * (r_x + ONE_X);
        expired   = cnt_q == CW'(TIMEOUT - 1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ISSUE;
                    data_in_d = operand;
                end
            end
            ISSUE: begin
                state_d = WAIT_CLR;
                cnt_d   = '0;
            end
            WAIT_CLR, WAIT_DONE: begin
                cnt_d = cnt_q + CW'(1);
                if (state_q == WAIT_CLR && !done) begin
                    state_d = WAIT_DONE;
                    cnt_d   = '0;
                end else if (state_q == WAIT_DONE && done) begin
                    state_d  = CHECK;
                    result_d = raiz;
                    cycles_d = ciclos;
                end else if (expired) begin
                    state_d   = REPORT;
                    result_d  = '0;
                    cycles_d  = '0;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            CHECK: begin
                state_d   = REPORT;
                error_d   = !(lo <= op_x && op_x < hi);
                timeout_d = 1'b0;
            end
            REPORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            data_in_q    <= '0;
            result_q     <= '0;
            cycles_q     <= '0;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            cnt_q        <= '0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_in_q    <= data_in_d;
            result_q     <= result_d;
            cycles_q     <= cycles_d;
            error_q      <= error_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
            data_ready_q <= state_d == ISSUE;
            busy_q       <= state_d != IDLE;
            valid_q      <= state_d == REPORT;
        end
    end
    assign data_in    = data_in_q;
    assign data_ready = data_ready_q;
    assign busy       = busy_q;
    assign result     = result_q;
    assign cycles     = cycles_q;
    assign valid      = valid_q;
    assign error      = error_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_raiz_requester.sv
// tb_raiz_requester: randomized scoreboard bench with a behavioural accelerator and square-root reference.
module tb_raiz_requester;
    localparam int N  = 8;
    localparam int TO = 31;
    logic           clock = 1'b0;
    logic           reset, start, done;
    logic [N-1:0]   operand, data_in;
    logic           data_ready, busy, valid, error, timeout;
    logic [N/2-1:0] raiz, result;
    logic [3:0]     ciclos, cycles;
    typedef struct { int res; int cyc; int err; int to; int op; int at; } exp_t;
    exp_t sb[$];
    exp_t m;
    int checks = 0, passes = 0, cyc = 0, dr_count = 0, issued = 0;
    int acc_lat = 3, acc_drop = 0, resp_cnt = -1, drop_cnt = -1;
    bit acc_never = 1'b0;
    logic [N/2-1:0] acc_raiz = '0;
    logic [3:0]     acc_cyc = '0;

    raiz_requester #(.n(N), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start), .operand(operand),
        .data_in(data_in), .data_ready(data_ready), .done(done), .raiz(raiz),
        .ciclos(ciclos), .busy(busy), .result(result), .cycles(cycles),
        .valid(valid), .error(error), .timeout(timeout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int isqrt(input int v);
        int s = 0;
        while ((s + 1) * (s + 1) <= v) s++;
        return s;
    endfunction

    // accelerator: drops done acc_drop samples after a request, answers acc_lat samples after it
    initial begin
        done = 1'b0; raiz = '0; ciclos = '0;
        forever begin
            @(posedge clock); #1;
            if (!reset) begin
                resp_cnt = -1; drop_cnt = -1;
            end else begin
                if (data_ready) begin
                    dr_count++;
                    drop_cnt = acc_drop;
                    resp_cnt = acc_never ? -1 : acc_lat;
                end
                if (drop_cnt == 0) done = 1'b0;
                if (drop_cnt >= 0) drop_cnt--;
                if (resp_cnt == 0) begin
                    done = 1'b1; raiz = acc_raiz; ciclos = acc_cyc;
                end
                if (resp_cnt >= 0) resp_cnt--;
            end
        end
    end

    initial forever begin
        @(posedge clock); #1;
        if (valid) begin
            if (sb.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                m = sb.pop_front();
                chk("result", int'(result), m.res);
                chk("cycles", int'(cycles), m.cyc);
                chk("error", int'(error), m.err);
                chk("timeout", int'(timeout), m.to);
                chk("data_in_held", int'(data_in), m.op);
                chk("valid_cycle", cyc, m.at);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clock);
        while (busy && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (busy) chk("idle_wait_expired", 1, 0);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb.size() > 0; t++) @(negedge clock);
        if (sb.size() > 0) chk("drain_expired", sb.size(), 0);
    endtask

    // mode 0: answered, 1: never answers, 2: done stuck high so the stale-clear wait expires
    task automatic txn(input int op, input int r, input int cy, input int lat, input int drop,
                       input int mode, input bit dbl);
        exp_t e;
        int k, rr;
        wait_idle();
        rr        = r & ((1 << (N / 2)) - 1);
        acc_lat   = lat;
        acc_drop  = mode == 2 ? 1000 : drop;
        acc_never = mode != 0;
        acc_raiz  = rr[N/2-1:0];
        acc_cyc   = cy < 0 ? 4'($urandom) : 4'(cy);
        operand   = op[N-1:0];
        start     = 1'b1;
        k         = cyc + 1;
        issued++;
        e.op = op;
        if (mode == 0) begin
            e.res = rr; e.cyc = int'(acc_cyc); e.to = 0;
            e.err = (rr * rr <= op && op < (rr + 1) * (rr + 1)) ? 0 : 1;
            e.at  = k + lat + 2;
        end else begin
            e.res = 0; e.cyc = 0; e.err = 1; e.to = 1;
            e.at  = k + (mode == 1 ? 2 : 1) + TO;
        end
        sb.push_back(e);
        @(negedge clock);
        start   = 1'b0;
        operand = N'($urandom);
        if (dbl) begin
            @(negedge clock);
            start = 1'b1; operand = ~op[N-1:0];
            @(negedge clock);
            start = 1'b0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_data_ready"}, int'(data_ready), 0);
        chk({tag, "_data_in"}, int'(data_in), 0);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_cycles"}, int'(cycles), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    initial begin
        int op, s, c, r, d;
        reset = 1'b0; start = 1'b0; operand = '0;
        repeat (3) @(negedge clock);
        chk_zero("reset");
        reset = 1'b1;
        txn(144, 12, 5, 3, 0, 0, 0);
        txn(0, 0, -1, 2, 0, 0, 0);
        txn(255, 15, -1, 4, 0, 0, 0);
        txn(255, 16, -1, 3, 0, 0, 0);
        txn(144, 11, -1, 2, 0, 0, 0);
        txn(100, 10, -1, 3, 0, 1, 0);
        drain();
        repeat (3) @(negedge clock);
        chk("timeout_hold", int'(timeout), 1);
        chk("error_hold", int'(error), 1);
        chk("result_hold", int'(result), 0);
        txn(49, 7, -1, 3, 0, 0, 0);
        txn(81, 9, -1, 3, 0, 2, 0);
        txn(169, 13, -1, 6, 3, 0, 1);
        drain();
        wait_idle();
        acc_never = 1'b1; acc_drop = 0;
        operand = 8'd200; start = 1'b1; issued++;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b0;
        #1;
        chk_zero("abort");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        txn(196, 14, -1, 3, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 255));
            s  = isqrt(op);
            c  = int'($urandom_range(0, 9));
            r  = c == 0 ? s + 1 : c == 1 ? s - 1 : s;
            d  = c == 9 ? 0 : int'($urandom_range(0, 2));
            txn(op, r, -1, d + int'($urandom_range(2, 5)), d, c == 9 ? 1 : 0, 1'($urandom_range(0, 1)));
        end
        drain();
        repeat (4) @(negedge clock);
        chk("data_ready_count", dr_count, issued);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
